// File: rtl/ltlf_trace_player_if.sv
// Purpose: host + monitor signal bundle for ltlf_trace_player.
// Latency: n/a (wires only).
// Backpressure: none; host writes are dropped when the buffer is full or the player is busy.
// Ports (master = host/monitor side, slave = player side):
//   wr_en, wr_sym, clr_trace, start : host commands to the player
//   wr_full, len, busy              : buffer / player status
//   mon_rst, run, A, B              : stimulus to the LTLf monitor
//   report_in                       : monitor report back to the player
//   done, verdict                   : end-of-trace pulse and captured verdict
interface ltlf_trace_player_if #(
  parameter int AW = 4
);
  logic          wr_en;
  logic [1:0]    wr_sym;
  logic          clr_trace;
  logic          start;
  logic          wr_full;
  logic [AW:0]   len;
  logic          busy;
  logic          mon_rst;
  logic          run;
  logic          A;
  logic          B;
  logic          report_in;
  logic          done;
  logic          verdict;

  modport master (
    output wr_en, wr_sym, clr_trace, start, report_in,
    input  wr_full, len, busy, mon_rst, run, A, B, done, verdict
  );

  modport slave (
    input  wr_en, wr_sym, clr_trace, start, report_in,
    output wr_full, len, busy, mon_rst, run, A, B, done, verdict
  );
endinterface

// File: rtl/ltlf_trace_player.sv
// Purpose: buffers a finite {A,B} trace, replays it into an LTLf monitor, captures the verdict.
// Latency: start -> first run cycle 2 cycles; start -> done count+3 cycles (1 cycle for empty trace).
// Backpressure: none; wr_en/clr_trace/start are ignored while busy, writes dropped when full.
// Ports: clk, rst (sync, active-high) plus bus (slave modport of ltlf_trace_player_if):
//   host side  wr_en/wr_sym/clr_trace/start in, wr_full/len/busy/done/verdict out
//   monitor    mon_rst/run/A/B out, report_in in
module ltlf_trace_player #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  ltlf_trace_player_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    PLAY   = 3'd2,
    SETTLE = 3'd3,
    FIN    = 3'd4
  } state_t;

  localparam logic [AW:0] ONE   = (AW+1)'(1);
  localparam logic [AW:0] FULLC = (AW+1)'(DEPTH);

  state_t          state;
  state_t          state_nxt;
  logic [1:0]      mem [DEPTH];
  logic [AW:0]     count;
  logic [AW-1:0]   rd_ptr;
  logic            verdict_q;
  logic            full;
  logic            last_sym;
  logic            do_wr;

  assign full     = (count == FULLC);
  assign last_sym = ({1'b0, rd_ptr} == (count - ONE));

  // start takes priority over clr_trace, which takes priority over wr_en.
  assign do_wr = (state == IDLE) && !bus.start && !bus.clr_trace && bus.wr_en && !full;

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = (count == '0) ? FIN : CLR;
      CLR:     state_nxt = PLAY;
      PLAY:    if (last_sym) state_nxt = SETTLE;
      SETTLE:  state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode state/mem flops only, never the host inputs.
  always_comb begin
    bus.mon_rst = 1'b0;
    bus.run     = 1'b0;
    bus.A       = 1'b0;
    bus.B       = 1'b0;
    bus.done    = 1'b0;
    case (state)
      CLR:  bus.mon_rst = 1'b1;
      PLAY: begin
        bus.run = 1'b1;
        bus.A   = mem[rd_ptr][1];
        bus.B   = mem[rd_ptr][0];
      end
      FIN:  bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy    = (state != IDLE);
  assign bus.len     = count;
  assign bus.wr_full = full;
  assign bus.verdict = verdict_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      rd_ptr    <= '0;
      verdict_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.start) begin
            rd_ptr <= '0;
            // An empty trace has nothing to prove: it fails.
            if (count == '0) verdict_q <= 1'b0;
          end else if (bus.clr_trace) begin
            count <= '0;
          end else if (do_wr) begin
            count <= count + ONE;
          end
        end
        PLAY:    rd_ptr <= rd_ptr + 1'b1;
        // Monitor report is registered, so it reflects the last symbol during SETTLE.
        SETTLE:  verdict_q <= bus.report_in;
        default: ;
      endcase
    end
  end

  // Buffer storage carries no reset; contents are only read below count.
  always_ff @(posedge clk) begin
    if (do_wr) mem[count[AW-1:0]] <= bus.wr_sym;
  end

endmodule

// File: tb/tb_ltlf_trace_player.sv
module tb_ltlf_trace_player;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ltlf_trace_player_if #(.AW(4)) bus ();

  ltlf_trace_player #(.DEPTH(16), .AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Reference monitor for G(A -> F B): report high while no A is awaiting a B.
  logic pending;
  always_ff @(posedge clk) begin
    if (rst || bus.mon_rst) pending <= 1'b0;
    else if (bus.run)       pending <= (pending | bus.A) & ~bus.B;
  end
  assign bus.report_in = ~pending;

  // Playback observation results.
  int         mr_n, mr_cyc, run_n, run_first, gaps, done_cyc, ab_leak;
  logic       vd;
  logic [1:0] syms [32];
  logic [1:0] saved [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_sym(input logic [1:0] s);
    bus.wr_en  = 1'b1;
    bus.wr_sym = s;
    tick();
    bus.wr_en  = 1'b0;
  endtask

  task automatic clear_trace();
    bus.clr_trace = 1'b1;
    tick();
    bus.clr_trace = 1'b0;
  endtask

  // Pulse start, then log cycle by cycle (cycle 1 = first cycle after the start edge).
  task automatic watch(input bit inject);
    bit ended;
    ended = 0;
    mr_n = 0; mr_cyc = 0; run_n = 0; run_first = 0; gaps = 0; done_cyc = 0; ab_leak = 0; vd = 1'bx;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (inject && c == 3) begin
        bus.wr_en = 1'b1; bus.wr_sym = 2'b11; bus.clr_trace = 1'b1; bus.start = 1'b1;
      end
      if (bus.mon_rst) begin mr_n++; mr_cyc = c; end
      if (bus.run) begin
        if (ended) gaps++;
        if (run_n == 0) run_first = c;
        if (run_n < 32) syms[run_n] = {bus.A, bus.B};
        run_n++;
      end else begin
        if (run_n > 0) ended = 1;
        if (bus.A || bus.B) ab_leak++;
      end
      if (bus.done) begin
        done_cyc = c;
        vd = bus.verdict;
        break;
      end
      tick();
      bus.wr_en = 1'b0; bus.clr_trace = 1'b0; bus.start = 1'b0;
    end
    // done must be a single-cycle pulse followed by IDLE
    tick();
    chk("done_one_cycle", bus.done, 0);
    chk("idle_after_done", bus.busy, 0);
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_sym = 2'b00; bus.clr_trace = 1'b0; bus.start = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_len", bus.len, 0);
    chk("rst_full", bus.wr_full, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_run_monrst_ab_done", {bus.run, bus.mon_rst, bus.A, bus.B, bus.done}, 0);
    chk("rst_verdict", bus.verdict, 0);

    // 1: trace 10,00,01 -> verdict 1, done at cycle 6
    write_sym(2'b10); write_sym(2'b00); write_sym(2'b01);
    chk("t1_len", bus.len, 3);
    watch(0);
    chk("t1_monrst_n", mr_n, 1);
    chk("t1_monrst_cyc", mr_cyc, 1);
    chk("t1_run_first", run_first, 2);
    chk("t1_run_n", run_n, 3);
    chk("t1_syms", {syms[0], syms[1], syms[2]}, 6'b10_00_01);
    chk("t1_gaps_leak", gaps + ab_leak, 0);
    chk("t1_done_cyc", done_cyc, 6);
    chk("t1_verdict", vd, 1);
    chk("t1_verdict_held", bus.verdict, 1);
    chk("t1_len_kept", bus.len, 3);

    // clr_trace wins over a simultaneous wr_en
    bus.wr_en = 1'b1; bus.wr_sym = 2'b11; bus.clr_trace = 1'b1;
    tick();
    bus.wr_en = 1'b0; bus.clr_trace = 1'b0;
    chk("clr_wins", bus.len, 0);

    // 2: single A, never answered -> verdict 0, done at cycle 4
    write_sym(2'b10);
    watch(0);
    chk("t2_run_n", run_n, 1);
    chk("t2_sym", syms[0], 2'b10);
    chk("t2_done_cyc", done_cyc, 4);
    chk("t2_verdict", vd, 0);

    // 3: 17 writes, 17th dropped
    clear_trace();
    for (int i = 0; i < 16; i++) write_sym(2'(i));
    chk("t3_len16", bus.len, 16);
    chk("t3_full", bus.wr_full, 1);
    write_sym(2'b00);
    chk("t3_len_after17", bus.len, 16);
    watch(0);
    chk("t3_run_n", run_n, 16);
    chk("t3_sym15", syms[15], 2'b11);
    chk("t3_sym5", syms[5], 2'b01);
    chk("t3_sym14", syms[14], 2'b10);
    chk("t3_gaps", gaps, 0);
    chk("t3_done_cyc", done_cyc, 19);
    chk("t3_verdict", vd, 1);

    // 4: empty trace -> immediate fail
    clear_trace();
    chk("t4_len", bus.len, 0);
    watch(0);
    chk("t4_monrst_n", mr_n, 0);
    chk("t4_run_n", run_n, 0);
    chk("t4_done_cyc", done_cyc, 1);
    chk("t4_verdict", vd, 0);

    // 6: host commands during playback are ignored; replay is identical
    write_sym(2'b01); write_sym(2'b10); write_sym(2'b11);
    watch(1);
    chk("t6_run_n", run_n, 3);
    chk("t6_syms", {syms[0], syms[1], syms[2]}, 6'b01_10_11);
    chk("t6_done_cyc", done_cyc, 6);
    chk("t6_verdict", vd, 1);
    chk("t6_len", bus.len, 3);
    for (int i = 0; i < 3; i++) saved[i] = syms[i];
    watch(0);
    chk("t6_rep_run_n", run_n, 3);
    chk("t6_rep_syms", {syms[0], syms[1], syms[2]}, {saved[0], saved[1], saved[2]});
    chk("t6_rep_done_cyc", done_cyc, 6);
    chk("t6_rep_verdict", vd, 1);

    // 5: reset in the 2nd PLAY cycle of a 5-symbol trace
    clear_trace();
    for (int i = 0; i < 5; i++) write_sym(2'b10);
    bus.start = 1'b1;
    tick();                 // cycle 1: CLR
    bus.start = 1'b0;
    tick();                 // cycle 2: PLAY #1
    chk("t5_playing", bus.run, 1);
    tick();                 // cycle 3: PLAY #2
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_run", bus.run, 0);
    chk("t5_busy", bus.busy, 0);
    chk("t5_len", bus.len, 0);
    chk("t5_done", bus.done, 0);
    chk("t5_verdict", bus.verdict, 0);
    begin
      int dn;
      dn = 0;
      for (int i = 0; i < 10; i++) begin
        if (bus.done || bus.run) dn++;
        tick();
      end
      chk("t5_no_done_after", dn, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
